// File: rtl/vip_slave_model.sv
// vip_slave_model
//   Behavioural-but-synthesizable slave used as a verification IP target.
//   It accepts one request/acknowledge transaction at a time against a
//   word-addressed memory. The acknowledge comes LATENCY cycles after the
//   request is sampled. With STALL_EN=1, pseudo-random wait states are
//   added to that delay. The module also counts completed reads and writes
//   and flags requests that are withdrawn before they complete.
//
// Parameters
//   ADDR_W    address width
//   DATA_W    data width
//   MEM_AW    word-index width (memory depth 2**MEM_AW)
//   LATENCY   cycles from request sample to ack (1..15)
//   STALL_EN  1 enables LFSR-driven wait-state insertion
//   LFSR_SEED nonzero seed of the 16-bit stall LFSR
//
// Ports
//   clk          clock, rising edge
//   aresetn      asynchronous active-low reset
//   slave_req    request, held by the master until ack
//   slave_addr   byte/word address, only [MEM_AW-1:0] is decoded
//   slave_cmd    1 write, 0 read
//   slave_wdata  write data
//   slave_ack    one-cycle completion strobe
//   slave_rdata  read data, nonzero only during a read ack
//   wr_cnt       completed writes, saturating
//   rd_cnt       completed reads, saturating
//   proto_err    sticky flag: request dropped before completion
module vip_slave_model #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          MEM_AW    = 8,
  parameter int          LATENCY   = 1,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic              proto_err
);

  localparam int         DEPTH    = 2 ** MEM_AW;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [1:0]        stall_run;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              stalled;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the low word index by design.
  logic              unused_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx         = slave_addr[MEM_AW-1:0];
  assign unused_addr = ^slave_addr;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // A stall run is capped at three cycles so the worst-case latency stays bounded.
  assign stalled = (STALL_EN != 0) && (state == WAIT) && lfsr[0] && (stall_run != 2'd3);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      stall_run   <= '0;
      lfsr        <= LFSR_SEED;
      slave_ack   <= 1'b0;
      slave_rdata <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      proto_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};

      case (state)
        IDLE: begin
          slave_ack   <= 1'b0;
          slave_rdata <= '0;
          stall_run   <= '0;
          if (slave_req) begin
            // lat_cnt holds the number of unstalled WAIT cycles still to go;
            // ACK is entered on the cycle that takes it to zero, which gives
            // an ack period of LATENCY+1 for back-to-back requests.
            lat_cnt <= LAT_INIT;
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state       <= ACK;
              slave_ack   <= 1'b1;
              slave_rdata <= slave_cmd ? '0 : mem[idx];
            end
          end
        end

        WAIT: begin
          if (!slave_req) begin
            state     <= IDLE;
            proto_err <= 1'b1;
            stall_run <= '0;
          end else if (stalled) begin
            stall_run <= stall_run + 2'd1;
          end else begin
            stall_run <= '0;
            lat_cnt   <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              state       <= ACK;
              slave_ack   <= 1'b1;
              slave_rdata <= slave_cmd ? '0 : mem[idx];
            end
          end
        end

        ACK: begin
          // The transaction commits only if the request is still held on the exit edge.
          state       <= IDLE;
          slave_ack   <= 1'b0;
          slave_rdata <= '0;
          if (!slave_req) begin
            proto_err <= 1'b1;
          end else if (slave_cmd) begin
            mem[idx] <= slave_wdata;
            wr_cnt   <= sat_inc(wr_cnt);
          end else begin
            rd_cnt <= sat_inc(rd_cnt);
          end
        end

        default: begin
          state       <= IDLE;
          slave_ack   <= 1'b0;
          slave_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_slave_model.sv
// tb_vip_slave_model
//   Directed bench for vip_slave_model. It uses three instances:
//   LATENCY=1; LATENCY=4; and LATENCY=3 with stalls enabled.
//   All instances share clk and aresetn.
module tb_vip_slave_model;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  cmd = '0;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  ack;
  logic [2:0]  perr;
  logic [31:0] rdata [3];
  logic [15:0] wr_cnt [3];
  logic [15:0] rd_cnt [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vip_slave_model #(.LATENCY(1)) u_l1 (
    .clk(clk), .aresetn(aresetn), .slave_req(req[0]), .slave_addr(addr[0]),
    .slave_cmd(cmd[0]), .slave_wdata(wdata[0]), .slave_ack(ack[0]),
    .slave_rdata(rdata[0]), .wr_cnt(wr_cnt[0]), .rd_cnt(rd_cnt[0]),
    .proto_err(perr[0])
  );

  vip_slave_model #(.LATENCY(4)) u_l4 (
    .clk(clk), .aresetn(aresetn), .slave_req(req[1]), .slave_addr(addr[1]),
    .slave_cmd(cmd[1]), .slave_wdata(wdata[1]), .slave_ack(ack[1]),
    .slave_rdata(rdata[1]), .wr_cnt(wr_cnt[1]), .rd_cnt(rd_cnt[1]),
    .proto_err(perr[1])
  );

  vip_slave_model #(.LATENCY(3), .STALL_EN(1)) u_l3s (
    .clk(clk), .aresetn(aresetn), .slave_req(req[2]), .slave_addr(addr[2]),
    .slave_cmd(cmd[2]), .slave_wdata(wdata[2]), .slave_ack(ack[2]),
    .slave_rdata(rdata[2]), .wr_cnt(wr_cnt[2]), .rd_cnt(rd_cnt[2]),
    .proto_err(perr[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on instance k; lat counts edges from the sample
  // edge up to and including the edge that raises ack.
  task automatic do_txn(input int k, input logic c, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd);
    req[k]   = 1'b1;
    cmd[k]   = c;
    addr[k]  = a;
    wdata[k] = d;
    lat = 0;
    rd  = '0;
    while (1) begin
      tick();
      lat++;
      if (ack[k]) break;
      if (lat >= 100) begin
        chk($sformatf("ack_timeout_%0d", k), 32'(ack[k]), 32'd1);
        req[k] = 1'b0;
        return;
      end
    end
    rd = rdata[k];
    tick();
    chk($sformatf("ack_one_cycle_%0d", k), 32'(ack[k]), 32'd0);
    req[k] = 1'b0;
  endtask

  initial begin
    int          lat;
    int          min_lat;
    int          max_lat;
    int          bad_data;
    logic [31:0] rd;

    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end

    // Reset values while aresetn is held low
    repeat (3) tick();
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_rdata", rdata[0],       32'd0);
    chk("rst_wrcnt", 32'(wr_cnt[0]), 32'd0);
    chk("rst_rdcnt", 32'(rd_cnt[1]), 32'd0);
    chk("rst_perr",  32'(perr),      32'd0);
    aresetn = 1'b1;
    tick();

    // LATENCY=1 write/read round trip, aliasing, unwritten location
    do_txn(0, 1'b1, 32'h05, 32'hDEADBEEF, lat, rd);
    chk("l1_wr_lat",   32'(lat),       32'd1);
    chk("l1_wr_rdata", rd,             32'd0);
    chk("l1_wr_cnt",   32'(wr_cnt[0]), 32'd1);
    do_txn(0, 1'b0, 32'h05, 32'h0, lat, rd);
    chk("l1_rd_lat",   32'(lat),       32'd1);
    chk("l1_rd_data",  rd,             32'hDEADBEEF);
    chk("l1_rd_cnt",   32'(rd_cnt[0]), 32'd1);
    chk("l1_rdata_idle", rdata[0],     32'd0);
    do_txn(0, 1'b0, 32'h7F, 32'h0, lat, rd);
    chk("l1_unwritten", rd, 32'd0);
    do_txn(0, 1'b1, 32'h105, 32'h12345678, lat, rd);
    do_txn(0, 1'b0, 32'h05, 32'h0, lat, rd);
    chk("l1_alias",     rd,             32'h12345678);
    chk("l1_wr_cnt2",   32'(wr_cnt[0]), 32'd2);
    chk("l1_rd_cnt3",   32'(rd_cnt[0]), 32'd3);
    chk("l1_perr",      32'(perr[0]),   32'd0);

    // LATENCY=4, request held for three reads: ack every 5 cycles
    req[1]  = 1'b1;
    cmd[1]  = 1'b0;
    addr[1] = 32'h10;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("b2b_ack_c%0d", i), 32'(ack[1]), 32'((i % 5) == 4));
    end
    req[1] = 1'b0;
    tick();
    chk("b2b_rd_cnt", 32'(rd_cnt[1]), 32'd3);
    chk("b2b_perr",   32'(perr[1]),   32'd0);

    // LATENCY=3 with stalls: bounded latency over 1000 reads
    do_txn(2, 1'b1, 32'h09, 32'hA5A5A5A5, lat, rd);
    chk("st_wr_lat_range", 32'(lat >= 3 && lat <= 12), 32'd1);
    min_lat  = 1000;
    max_lat  = 0;
    bad_data = 0;
    for (int n = 0; n < 1000; n++) begin
      do_txn(2, 1'b0, 32'h09, 32'h0, lat, rd);
      if (lat < min_lat) min_lat = lat;
      if (lat > max_lat) max_lat = lat;
      if (rd !== 32'hA5A5A5A5) bad_data++;
    end
    chk("st_min_lat",    32'(min_lat >= 3),  32'd1);
    chk("st_max_lat",    32'(max_lat <= 12), 32'd1);
    chk("st_stall_seen", 32'(max_lat > 3),   32'd1);
    chk("st_bad_data",   32'(bad_data),      32'd0);
    chk("st_rd_cnt",     32'(rd_cnt[2]),     32'd1000);
    chk("st_wr_cnt",     32'(wr_cnt[2]),     32'd1);
    chk("st_perr_clean", 32'(perr[2]),       32'd0);

    // Request withdrawn while waiting
    req[2]   = 1'b1;
    cmd[2]   = 1'b1;
    addr[2]  = 32'h09;
    wdata[2] = 32'h11111111;
    tick();
    chk("ab_ack_e0", 32'(ack[2]), 32'd0);
    tick();
    chk("ab_ack_e1", 32'(ack[2]), 32'd0);
    req[2] = 1'b0;
    tick();
    chk("ab_ack_e2", 32'(ack[2]),    32'd0);
    chk("ab_perr",   32'(perr[2]),   32'd1);
    chk("ab_wr_cnt", 32'(wr_cnt[2]), 32'd1);
    repeat (3) tick();
    do_txn(2, 1'b0, 32'h09, 32'h0, lat, rd);
    chk("ab_mem_kept",   rd,             32'hA5A5A5A5);
    chk("ab_perr_stick", 32'(perr[2]),   32'd1);
    chk("ab_rd_cnt",     32'(rd_cnt[2]), 32'd1001);

    // Reset asserted during WAIT of a write
    req[1]   = 1'b1;
    cmd[1]   = 1'b1;
    addr[1]  = 32'h03;
    wdata[1] = 32'hCAFEF00D;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    chk("rw_ack",    32'(ack[1]),    32'd0);
    chk("rw_wr_cnt", 32'(wr_cnt[1]), 32'd0);
    chk("rw_rd_cnt", 32'(rd_cnt[1]), 32'd0);
    chk("rw_perr",   32'(perr[2]),   32'd0);
    req[1] = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    do_txn(1, 1'b0, 32'h03, 32'h0, lat, rd);
    chk("rw_rd_lat",  32'(lat),       32'd4);
    chk("rw_rd_data", rd,             32'd0);
    chk("rw_wr_cnt2", 32'(wr_cnt[1]), 32'd0);
    chk("rw_rd_cnt2", 32'(rd_cnt[1]), 32'd1);
    do_txn(0, 1'b0, 32'h05, 32'h0, lat, rd);
    chk("rw_mem_clr", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
